// File: rtl/sub_frame_ctrl.sv
// sub_frame_ctrl: frame sequencer for the subtraction datapath.
// Accepts FRAME_LEN samples, writes them with 1-cycle registered latency,
// pulses refresh after the last write, waits for the datapath result,
// then captures it and counts the completed frame.
module sub_frame_ctrl #(
    parameter int FRAME_LEN  = 18001,
    parameter int RESULT_LAT = 2
) (
    input  logic        clk_200M,
    input  logic        rst_200M,
    input  logic        i_start,
    input  logic        i_cont,
    input  logic        i_abort,
    input  logic        i_vld,
    input  logic [39:0] i_data,
    output logic        o_rdy,
    output logic [14:0] o_rec_addr,
    output logic        o_rec_ce,
    output logic        o_rec_we,
    output logic [39:0] o_rec_d,
    output logic        o_refresh,
    input  logic [25:0] i_sum_traction,
    output logic [25:0] o_sum,
    output logic        o_sum_vld,
    output logic        o_busy,
    output logic [15:0] o_frame_cnt
);

    localparam logic [14:0] LAST_IDX = 15'(FRAME_LEN - 1);
    localparam logic [3:0]  WAIT_END = 4'(RESULT_LAT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STREAM,
        ST_REFRESH,
        ST_WAIT,
        ST_REPORT
    } state_t;

    state_t      state_reg;
    logic [14:0] idx_reg;
    logic [3:0]  wait_cnt_reg;
    logic [14:0] rec_addr_reg;
    logic        rec_ce_reg;
    logic        rec_we_reg;
    logic        refresh_reg;
    logic [25:0] sum_reg;
    logic        sum_vld_reg;
    logic [15:0] frame_cnt_reg;
    logic        wr_en;

    // A sample is written only when accepted and not abandoned the same cycle.
    assign wr_en = i_vld && (state_reg == ST_STREAM) && !i_abort;

    // Per-lane data register: loads on a write, holds otherwise.
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_lane
            logic [7:0] lane_reg;
            // Capture this 8-bit lane of the accepted sample.
            always_ff @(posedge clk_200M) begin
                if (rst_200M) begin
                    lane_reg <= '0;
                end else if (wr_en) begin
                    lane_reg <= i_data[gi*8 +: 8];
                end
            end
            assign o_rec_d[gi*8 +: 8] = lane_reg;
        end
    endgenerate

    // Frame sequencing FSM with registered datapath/result outputs.
    always_ff @(posedge clk_200M) begin
        if (rst_200M) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= '0;
            wait_cnt_reg  <= '0;
            rec_addr_reg  <= '0;
            rec_ce_reg    <= 1'b0;
            rec_we_reg    <= 1'b0;
            refresh_reg   <= 1'b0;
            sum_reg       <= '0;
            sum_vld_reg   <= 1'b0;
            frame_cnt_reg <= '0;
        end else begin
            // Pulse outputs default low; address and sum hold.
            rec_ce_reg  <= 1'b0;
            rec_we_reg  <= 1'b0;
            refresh_reg <= 1'b0;
            sum_vld_reg <= 1'b0;
            if (i_abort) begin
                // Abort beats everything, including a start in IDLE.
                state_reg <= ST_IDLE;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (i_start) begin
                            state_reg <= ST_STREAM;
                            idx_reg   <= '0;
                        end
                    end
                    ST_STREAM: begin
                        if (i_vld) begin
                            rec_ce_reg   <= 1'b1;
                            rec_we_reg   <= 1'b1;
                            rec_addr_reg <= idx_reg;
                            if (idx_reg == LAST_IDX) begin
                                state_reg <= ST_REFRESH;
                            end else begin
                                idx_reg <= idx_reg + 15'd1;
                            end
                        end
                    end
                    ST_REFRESH: begin
                        // Refresh lands one cycle after the final write pulse.
                        refresh_reg  <= 1'b1;
                        wait_cnt_reg <= '0;
                        state_reg    <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (wait_cnt_reg == WAIT_END) begin
                            state_reg <= ST_REPORT;
                        end else begin
                            wait_cnt_reg <= wait_cnt_reg + 4'd1;
                        end
                    end
                    ST_REPORT: begin
                        sum_reg       <= i_sum_traction;
                        sum_vld_reg   <= 1'b1;
                        frame_cnt_reg <= frame_cnt_reg + 16'd1;
                        if (i_cont) begin
                            state_reg <= ST_STREAM;
                            idx_reg   <= '0;
                        end else begin
                            state_reg <= ST_IDLE;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    assign o_rdy       = (state_reg == ST_STREAM);
    assign o_busy      = (state_reg != ST_IDLE);
    assign o_rec_addr  = rec_addr_reg;
    assign o_rec_ce    = rec_ce_reg;
    assign o_rec_we    = rec_we_reg;
    assign o_refresh   = refresh_reg;
    assign o_sum       = sum_reg;
    assign o_sum_vld   = sum_vld_reg;
    assign o_frame_cnt = frame_cnt_reg;

endmodule

// File: doc/sub_frame_ctrl.md
SUB_FRAME_CTRL -- requirements
Module: sub_frame_ctrl

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 18001, samples per frame; legal range 1..32768.
REQ-002 SHALL have parameter RESULT_LAT, default 2, cycles from refresh pulse to sampling i_sum_traction; legal range 1..15.
REQ-003 SHALL have port clk_200M  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst_200M  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port i_start  in  1  one-cycle request to begin a frame.
REQ-006 SHALL have port i_cont  in  1  1 = start the next frame automatically after the result.
REQ-007 SHALL have port i_abort  in  1  abandon the current frame.
REQ-008 SHALL have port i_vld  in  1  input sample valid.
REQ-009 SHALL have port i_data  in  40  input sample, five 8-bit lanes.
REQ-010 SHALL have port o_rdy  out  1  sample accepted when i_vld & o_rdy.
REQ-011 SHALL have port o_rec_addr  out  15  write address to subtraction datapath.
REQ-012 SHALL have port o_rec_ce  out  1  datapath chip enable.
REQ-013 SHALL have port o_rec_we  out  1  datapath write enable.
REQ-014 SHALL have port o_rec_d  out  40  datapath write data.
REQ-015 SHALL have port o_refresh  out  1  end-of-frame pulse to datapath.
REQ-016 SHALL have port i_sum_traction  in  26  datapath accumulated result.
REQ-017 SHALL have port o_sum  out  26  captured frame result.
REQ-018 SHALL have port o_sum_vld  out  1  one-cycle pulse, o_sum updated.
REQ-019 SHALL have port o_busy  out  1  high in any state other than IDLE.
REQ-020 SHALL have port o_frame_cnt  out  16  completed-frame count.

Function
REQ-021 SHALL implement FSM states IDLE, STREAM, REFRESH, WAIT, REPORT.
REQ-022 IDLE: i_start=1 -> STREAM, with the sample index cleared to 0; otherwise remain in IDLE.
REQ-023 o_rdy SHALL be 1 only in STREAM; it is a combinational decode of the state.
REQ-024 Accept (i_vld & o_rdy): next cycle o_rec_ce=o_rec_we=1, o_rec_addr=index, o_rec_d=i_data (1-cycle registered latency); index increments by 1.
REQ-025 Cycle without accept: next cycle o_rec_ce=o_rec_we=0; o_rec_addr and o_rec_d hold.
REQ-026 Accept with index==FRAME_LEN-1: STREAM -> REFRESH; no further samples accepted in this frame.
REQ-027 REFRESH: o_refresh=1 for exactly one cycle, coincident with the cycle after the final write (the final write pulse precedes it); -> WAIT.
REQ-028 WAIT: count RESULT_LAT cycles, then -> REPORT.
REQ-029 REPORT: o_sum<=i_sum_traction and o_frame_cnt<=o_frame_cnt+1 (wraps 0xFFFF->0); the next cycle carries the o_sum_vld pulse.
REQ-030 Exit from REPORT: if i_cont=1 -> STREAM with index cleared to 0; otherwise -> IDLE.
REQ-031 o_sum SHALL hold its value until the next REPORT.
REQ-032 i_start outside IDLE SHALL be ignored (not queued).
REQ-033 i_abort in any non-IDLE state SHALL force IDLE next cycle, with no refresh, no o_sum_vld, no count change; o_rec_ce/o_rec_we=0 next cycle.
REQ-034 i_abort in IDLE together with i_start: abort wins; remain in IDLE.
REQ-035 FRAME_LEN=1: first accept goes directly to REFRESH.
REQ-036 The index SHALL never exceed FRAME_LEN-1; o_rec_addr is the low 15 bits.

Reset
REQ-037 With rst_200M=1 at a clock edge, the next state SHALL be IDLE, with index=0, o_rec_addr=0, o_rec_d=0, o_rec_ce=0, o_rec_we=0, o_refresh=0, o_sum=0, o_sum_vld=0, o_frame_cnt=0; o_rdy=0, o_busy=0.
REQ-038 Reset SHALL override i_start and i_abort, and takes effect mid-frame without a refresh pulse.

Verification
REQ-039 FRAME_LEN=4, i_start, i_vld constant 1, data 0xFF..FF -> writes to addr 0..3 on consecutive cycles; o_refresh one cycle later; o_sum_vld RESULT_LAT+2 cycles after refresh; o_frame_cnt=1.
REQ-040 i_vld toggling 1,0,1,0 -> o_rec_ce pattern 1,0,1,0; addresses 0,1 with no gaps skipped; d matches the accepted samples.
REQ-041 i_cont=1, FRAME_LEN=18001, 4 frames -> 4 o_sum_vld pulses, o_frame_cnt=4, each frame's address range 0..18000, one refresh per frame.
REQ-042 i_abort at index 100 -> IDLE next cycle; no o_refresh, no o_sum_vld; o_frame_cnt unchanged; the following i_start restarts at addr 0.
REQ-043 rst_200M=1 for one cycle during WAIT -> all outputs at reset values the next cycle; no o_sum_vld.
REQ-044 i_start pulsed during STREAM -> ignored; frame completes normally with exactly FRAME_LEN writes.
